// File: rtl/mul_issue_sched.sv
// Issue scheduler sharing one fixed-latency iterative multiplier with the 5-stage pipeline.
// Optional early termination is enabled by defining MUL_EARLY_DONE_EN.
module mul_issue_sched #(
  parameter int unsigned LAT = 4,
  parameter int unsigned CW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StartE,
  input  logic          KillE,
  input  logic [3:0]    WA3E,
  input  logic [3:0]    RA1D,
  input  logic [3:0]    RA2D,
  input  logic [3:0]    WA3D,
  input  logic          RegWriteD,
  input  logic          EarlyDone,
  output logic          UnitStart,
  output logic          MulBusy,
  output logic [3:0]    MulWA3,
  output logic          MulSelM,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushE
);

  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] wa3_q, wa3_nxt;

  logic start_live;
  logic hit_e;
  logic hit_m;
  logic early;

  assign start_live = StartE & ~KillE;

  // Decode operands colliding with the MUL being accepted, or with the pending one
  assign hit_e = (RA1D == WA3E) | (RA2D == WA3E) | (RegWriteD & (WA3D == WA3E));
  assign hit_m = (RA1D == wa3_q) | (RA2D == wa3_q) | (RegWriteD & (WA3D == wa3_q));

`ifdef MUL_EARLY_DONE_EN
  assign early = EarlyDone;
`else
  logic unused_early_done;
  assign unused_early_done = EarlyDone;
  assign early = 1'b0;
`endif

  // State, latency counter and pending destination
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      wa3_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wa3_q <= wa3_nxt;
    end
  end

  // Next state and hazard outputs; reset forces every output low in the reset cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wa3_nxt   = wa3_q;
    UnitStart = 1'b0;
    MulBusy   = 1'b0;
    MulSelM   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushE    = 1'b0;

    case (state)
      IDLE: begin
        if (start_live) begin
          UnitStart = 1'b1;
          wa3_nxt   = WA3E;
          cnt_nxt   = CW'(LAT - 1);
          state_nxt = BUSY;
          if (hit_e) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      end

      BUSY: begin
        MulBusy = 1'b1;
        cnt_nxt = (cnt == '0) ? '0 : cnt - CW'(1);
        if ((cnt == '0) || early) begin
          state_nxt = DONE;
        end
        // A second MUL holds in Execute; that outranks bubbling a dependent op
        if (start_live) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
        end else if (hit_m) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end

      DONE: begin
        MulBusy   = 1'b1;
        MulSelM   = 1'b1;
        StallF    = 1'b1;
        StallD    = 1'b1;
        StallE    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (reset) begin
      UnitStart = 1'b0;
      MulBusy   = 1'b0;
      MulSelM   = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushE    = 1'b0;
    end
  end

  assign MulWA3 = reset ? '0 : wa3_q;

endmodule
